// File: rtl/switch_block_cfg_pkg.sv
// Shared definitions for the configurable switch block: side indices,
// select codes, FSM states and compile-time helpers for chain layout.
package switch_block_cfg_pkg;

  localparam int SB_L = 0;
  localparam int SB_T = 1;
  localparam int SB_R = 2;
  localparam int SB_B = 3;

  // Select code per destination track: off, or source side (d+k) mod 4
  typedef enum logic [1:0] {
    SB_OFF      = 2'd0,
    SB_CW       = 2'd1,
    SB_STRAIGHT = 2'd2,
    SB_CCW      = 2'd3
  } sb_sel_e;

  typedef enum logic {
    ST_UNCFG  = 1'b0,
    ST_ACTIVE = 1'b1
  } sb_state_e;

  // Number of present sides
  function automatic int sb_popcount(logic [3:0] m);
    int n;
    n = 0;
    for (int b = 0; b < 4; b++) n += int'(m[b]);
    return n;
  endfunction

  // Position of side s among the present sides (order L,T,R,B)
  function automatic int sb_side_pos(logic [3:0] m, int s);
    int n;
    n = 0;
    for (int b = 0; b < 4; b++) if (b < s) n += int'(m[b]);
    return n;
  endfunction

endpackage

// File: rtl/switch_block_cfg_if.sv
// Config scan/commit and track bus of the switch block.
// master = fabric/configuration driver, slave = switch block.
interface switch_block_cfg_if #(parameter int W = 4);
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         cfg_commit;
  logic         cfg_valid;
  logic         cfg_err;
  logic [W-1:0] in_l, in_t, in_r, in_b;
  logic [W-1:0] out_l, out_t, out_r, out_b;

  modport master (
    output scan_en, scan_in, cfg_commit, in_l, in_t, in_r, in_b,
    input  scan_out, cfg_valid, cfg_err, out_l, out_t, out_r, out_b
  );

  modport slave (
    input  scan_en, scan_in, cfg_commit, in_l, in_t, in_r, in_b,
    output scan_out, cfg_valid, cfg_err, out_l, out_t, out_r, out_b
  );
endinterface

// File: rtl/switch_block_cfg_side_mux.sv
// One destination side: W 4:1 track muxes. Sources arrive pre-rotated by
// side (cw = d+1, st = d+2, ccw = d+3) and already zeroed if absent; the
// track index rotation happens here.
module sb_side_mux
  import switch_block_cfg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]      src_cw_i,
  input  logic [W-1:0]      src_st_i,
  input  logic [W-1:0]      src_ccw_i,
  input  logic [W-1:0][1:0] sel_i,
  output logic [W-1:0]      out_o
);

  // Per-track select with cw -> i+1, straight -> i, ccw -> i-1
  always_comb begin
    out_o = '0;
    for (int i = 0; i < W; i++) begin
      case (sel_i[i])
        SB_CW:       out_o[i] = src_cw_i[(i + 1) % W];
        SB_STRAIGHT: out_o[i] = src_st_i[i];
        SB_CCW:      out_o[i] = src_ccw_i[(i + W - 1) % W];
        default:     out_o[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/switch_block_cfg.sv
// Parametrised switch block with double-buffered configuration: a shadow
// scan chain loads in the background and a parity-checked commit copies it
// into per-side active select registers. Outputs stay 0 until configured.
module switch_block_cfg
  import switch_block_cfg_pkg::*;
#(
  parameter int         W       = 4,
  parameter logic [3:0] SIDE_EN = 4'b0111,
  parameter bit         REG_OUT = 1'b0
) (
  input logic              clk,
  input logic              rst,
  switch_block_cfg_if.slave bus
);

  localparam int NSIDES    = sb_popcount(SIDE_EN);
  localparam int CHAIN_LEN = 1 + NSIDES * W * 2;  // assumes at least one side

  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  sb_state_e            state_q;
  logic                 valid_q, err_q;
  logic                 commit_ok;
  logic [3:0][W-1:0]    trk_raw, trk_in, mux_out, route_w, out_w;

  // Serial shift toward bit 0; bit 0 is the parity bit and scan_out
  always_comb begin
    shadow_d = shadow_q;
    if (bus.scan_en) shadow_d = {bus.scan_in, shadow_q[CHAIN_LEN-1:1]};
  end

  // Shadow chain register
  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  // A commit is accepted only when not shifting and the chain has even parity
  assign commit_ok = bus.cfg_commit & ~bus.scan_en & ~(^shadow_q);

  // Config FSM with registered valid/err status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNCFG;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_UNCFG: if (commit_ok) state_q <= ST_ACTIVE;
        default:  state_q <= ST_ACTIVE;
      endcase
      if (bus.cfg_commit) begin
        if (commit_ok) begin
          valid_q <= 1'b1;
          err_q   <= 1'b0;
        end else begin
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign trk_raw[SB_L] = bus.in_l;
  assign trk_raw[SB_T] = bus.in_t;
  assign trk_raw[SB_R] = bus.in_r;
  assign trk_raw[SB_B] = bus.in_b;

  // Absent sides contribute nothing as a source
  always_comb begin
    for (int s = 0; s < 4; s++) trk_in[s] = SIDE_EN[s] ? trk_raw[s] : '0;
  end

  for (genvar s = 0; s < 4; s++) begin : g_side
    if (SIDE_EN[s]) begin : g_on
      localparam int POS = sb_side_pos(SIDE_EN, s);
      logic [W-1:0][1:0] sel_q;

      // Active selects for this side, loaded from its shadow field on commit
      always_ff @(posedge clk) begin
        if (rst)            sel_q <= '0;
        else if (commit_ok) sel_q <= shadow_q[1 + 2*POS*W +: 2*W];
      end

      sb_side_mux #(.W(W)) u_mux (
        .src_cw_i  (trk_in[(s + 1) % 4]),
        .src_st_i  (trk_in[(s + 2) % 4]),
        .src_ccw_i (trk_in[(s + 3) % 4]),
        .sel_i     (sel_q),
        .out_o     (mux_out[s])
      );
    end else begin : g_off
      assign mux_out[s] = '0;
    end
  end

  // No routing before the first good commit, so no loops can form
  assign route_w = (state_q == ST_ACTIVE) ? mux_out : '0;

  if (REG_OUT) begin : g_reg
    logic [3:0][W-1:0] out_q;
    // Registered output stage, one cycle of latency
    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= route_w;
    end
    assign out_w = out_q;
  end else begin : g_comb
    assign out_w = route_w;
  end

  assign bus.out_l     = out_w[SB_L];
  assign bus.out_t     = out_w[SB_T];
  assign bus.out_r     = out_w[SB_R];
  assign bus.out_b     = out_w[SB_B];
  assign bus.scan_out  = shadow_q[0];
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_switch_block_cfg.sv
// Bench for switch_block_cfg: a combinational (REG_OUT=0) and a registered
// (REG_OUT=1) instance share the same stimulus and are both compared against
// a behavioural model of the routing rules.
module tb_switch_block_cfg;

  localparam int         W   = 4;
  localparam logic [3:0] SEN = 4'b0111;
  localparam int         CL  = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, scan_en, scan_in, cfg_commit;
  logic [W-1:0] in_l, in_t, in_r, in_b;

  switch_block_cfg_if #(.W(W)) bus0 ();
  switch_block_cfg_if #(.W(W)) bus1 ();

  assign bus0.scan_en = scan_en;  assign bus1.scan_en = scan_en;
  assign bus0.scan_in = scan_in;  assign bus1.scan_in = scan_in;
  assign bus0.cfg_commit = cfg_commit;  assign bus1.cfg_commit = cfg_commit;
  assign bus0.in_l = in_l;  assign bus1.in_l = in_l;
  assign bus0.in_t = in_t;  assign bus1.in_t = in_t;
  assign bus0.in_r = in_r;  assign bus1.in_r = in_r;
  assign bus0.in_b = in_b;  assign bus1.in_b = in_b;

  switch_block_cfg #(.W(W), .SIDE_EN(SEN), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .bus(bus0));
  switch_block_cfg #(.W(W), .SIDE_EN(SEN), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [CL-1:0] m_sh;
  int            m_sel [4][W];
  bit            m_valid, m_err;
  logic [W-1:0]  m_reg [4];
  int            t_sel [4][W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output of destination side d from the routing rules and current inputs
  function automatic logic [W-1:0] route(int d);
    logic [W-1:0] ins [4];
    logic [W-1:0] o;
    int k, s, t;
    ins[0] = in_l; ins[1] = in_t; ins[2] = in_r; ins[3] = in_b;
    o = '0;
    if (!m_valid || !SEN[d]) return o;
    for (int i = 0; i < W; i++) begin
      k = m_sel[d][i];
      if (k != 0) begin
        s = (d + k) % 4;
        t = (k == 1) ? (i + 1) % W : (k == 2) ? i : (i + W - 1) % W;
        if (SEN[s]) o[i] = ins[s][t];
      end
    end
    return o;
  endfunction

  task automatic check_all();
    chk("comb_out", {bus0.out_b, bus0.out_r, bus0.out_t, bus0.out_l},
        {route(3), route(2), route(1), route(0)});
    chk("reg_out", {bus1.out_b, bus1.out_r, bus1.out_t, bus1.out_l},
        {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    chk("comb_status", {bus0.cfg_valid, bus0.cfg_err, bus0.scan_out}, {m_valid, m_err, m_sh[0]});
    chk("reg_status", {bus1.cfg_valid, bus1.cfg_err, bus1.scan_out}, {m_valid, m_err, m_sh[0]});
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    logic [W-1:0] r [4];
    int j;
    for (int d = 0; d < 4; d++) r[d] = route(d);
    if (rst) begin
      m_sh = '0; m_valid = 0; m_err = 0;
      foreach (m_sel[a, b]) m_sel[a][b] = 0;
      for (int d = 0; d < 4; d++) m_reg[d] = '0;
    end else begin
      for (int d = 0; d < 4; d++) m_reg[d] = r[d];
      if (cfg_commit) begin
        if (scan_en || (^m_sh)) m_err = 1;
        else begin
          j = 0;
          for (int s = 0; s < 4; s++) if (SEN[s]) begin
            for (int i = 0; i < W; i++) m_sel[s][i] = int'((m_sh >> (1 + 2*(j*W + i))) & 25'd3);
            j++;
          end
          m_valid = 1; m_err = 0;
        end
      end
      if (scan_en) m_sh = {scan_in, m_sh[CL-1:1]};
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [CL-1:0] build_chain(bit bad_p);
    logic [CL-1:0] v;
    int j;
    v = '0; j = 0;
    for (int s = 0; s < 4; s++) if (SEN[s]) begin
      for (int i = 0; i < W; i++) v[1 + 2*(j*W + i) +: 2] = 2'(t_sel[s][i]);
      j++;
    end
    v[0] = (^v) ^ bad_p;
    return v;
  endfunction

  task automatic shift_chain(input logic [CL-1:0] v);
    for (int k = 0; k < CL; k++) begin
      scan_en = 1'b1; scan_in = v[k];
      tick();
    end
    scan_en = 1'b0; scan_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] l, t, r, b;
    logic [W-1:0] el, et, er, eb;
  } vec_t;

  vec_t          tab [5];
  logic [CL-1:0] chain, pat;
  logic [15:0]   prev_exp;

  initial begin
    // all-straight routing: out_l <- in_r, out_r <- in_l, T sees absent B, B absent
    tab[0] = '{4'hA, 4'h0, 4'h5, 4'h0, 4'h5, 4'h0, 4'hA, 4'h0};
    tab[1] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tab[2] = '{4'h0, 4'h9, 4'h3, 4'h6, 4'h3, 4'h0, 4'h0, 4'h0};
    tab[3] = '{4'hC, 4'h1, 4'h7, 4'h2, 4'h7, 4'h0, 4'hC, 4'h0};
    tab[4] = '{4'h1, 4'hE, 4'h8, 4'h4, 4'h8, 4'h0, 4'h1, 4'h0};

    rst = 1; scan_en = 0; scan_in = 0; cfg_commit = 0;
    in_l = 0; in_t = 0; in_r = 0; in_b = 0;
    repeat (2) begin @(posedge clk); model_edge(); end
    @(negedge clk);
    rst = 0;

    // 1: reset for two cycles in the middle of a shift
    for (int k = 0; k < 10; k++) begin scan_en = 1; scan_in = 1; tick(); end
    rst = 1; tick(); tick();
    rst = 0; scan_en = 0; scan_in = 0;
    #1;
    chk("t1_outs", {bus0.out_b, bus0.out_r, bus0.out_t, bus0.out_l,
                    bus1.out_b, bus1.out_r, bus1.out_t, bus1.out_l}, 32'h0);
    chk("t1_status", {bus0.cfg_valid, bus0.cfg_err, bus0.scan_out,
                      bus1.cfg_valid, bus1.cfg_err, bus1.scan_out}, 32'h0);

    // 2: all selects straight, table of input/output vectors
    foreach (t_sel[a, b]) t_sel[a][b] = 2;
    chain = build_chain(1'b0);
    shift_chain(chain);
    commit();
    prev_exp = '0;
    for (int v = 0; v < 5; v++) begin
      in_l = tab[v].l; in_t = tab[v].t; in_r = tab[v].r; in_b = tab[v].b;
      #1;
      chk("t2_out", {bus0.out_b, bus0.out_r, bus0.out_t, bus0.out_l},
          {tab[v].eb, tab[v].er, tab[v].et, tab[v].el});
      chk("t2_valid", bus0.cfg_valid, 1);
      if (v > 0) chk("t2_reg_lag", {bus1.out_b, bus1.out_r, bus1.out_t, bus1.out_l}, prev_exp);
      prev_exp = {tab[v].eb, tab[v].er, tab[v].et, tab[v].el};
      tick();
    end

    // 3: T side takes the cw source (R) with index i+1
    for (int i = 0; i < W; i++) t_sel[1][i] = 1;
    chain = build_chain(1'b0);
    shift_chain(chain);
    commit();
    in_l = 0; in_t = 0; in_r = 4'b0001; in_b = 0;
    #1;
    chk("t3_out_t", bus0.out_t, 4'h8);
    chk("t3_out_l", bus0.out_l, 4'h1);
    tick();

    // 4: flipped parity is rejected, old routing kept; good commit clears err
    shift_chain(build_chain(1'b1));
    commit();
    #1;
    chk("t4_err", {bus0.cfg_valid, bus0.cfg_err}, 2'b11);
    chk("t4_keep", bus0.out_t, 4'h8);
    tick();
    shift_chain(chain);
    commit();
    #1;
    chk("t4_clear", {bus0.cfg_valid, bus0.cfg_err}, 2'b10);
    tick();

    // 5: commit while shifting is rejected and the shift still happens
    scan_en = 1; scan_in = 1; cfg_commit = 1;
    tick();
    scan_en = 0; scan_in = 0; cfg_commit = 0;
    #1;
    chk("t5_err", bus0.cfg_err, 1'b1);
    chk("t5_keep", bus0.out_t, 4'h8);
    chk("t5_shift", bus0.scan_out, chain[1]);
    tick();

    // 6: scan_out reproduces the serial pattern CHAIN_LEN cycles later
    pat = 25'h1ABCDEF;
    shift_chain(pat);
    for (int k = 0; k < CL; k++) begin
      scan_en = 1; scan_in = 0;
      #1;
      chk("t6_scan", bus0.scan_out, pat[k]);
      tick();
    end
    scan_en = 0;

    // Random configurations through full good/bad loads
    for (int n = 0; n < 8; n++) begin
      foreach (t_sel[a, b]) t_sel[a][b] = int'($urandom_range(0, 3));
      chain = build_chain(bit'(($urandom % 3) == 0));
      for (int k = 0; k < CL; k++) begin
        in_l = 4'($urandom); in_t = 4'($urandom); in_r = 4'($urandom); in_b = 4'($urandom);
        scan_en = 1; scan_in = chain[k];
        tick();
      end
      scan_en = 0;
      commit();
      for (int c = 0; c < 10; c++) begin
        in_l = 4'($urandom); in_t = 4'($urandom); in_r = 4'($urandom); in_b = 4'($urandom);
        tick();
      end
    end

    // Fully random control traffic
    for (int n = 0; n < 300; n++) begin
      in_l = 4'($urandom); in_t = 4'($urandom); in_r = 4'($urandom); in_b = 4'($urandom);
      scan_en    = ($urandom % 4) != 0;
      scan_in    = 1'($urandom);
      cfg_commit = ($urandom % 8) == 0;
      rst        = ($urandom % 150) == 0;
      tick();
    end
    rst = 0; scan_en = 0; cfg_commit = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
